theta_page_unit: RTL and testbench

Keccak θ-step engine for the encoder datapath. It sits beside the state register and drives its page read and page write ports directly. It computes θ in two sequential sweeps over the 64 pages of 25 bits each:

- **Parity sweep:** collects column parities.
- **Apply sweep:** XORs the θ correction into every page and writes each page back in place.

---
 rtl/theta_page_unit.sv | 109 ++++++++++
 tb/tb_theta_page_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/theta_page_unit.sv
// Keccak theta step over a 64-page x 25-bit state register.
// A parity sweep collects column parities, then an apply sweep rewrites every page in place.
module theta_page_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [5:0]  read_page_line_index,
   input  logic [24:0] read_page_data,
   output logic        write_page,
   output logic [5:0]  write_page_line_index,
   output logic [24:0] write_page_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PARITY,
      S_APPLY,
      S_DONE
   } state_e;

   state_e      state, state_nxt;
   logic [5:0]  z, z_nxt;
   logic [4:0]  par_mem [64];
   logic [4:0]  col_par;
   logic [4:0]  c_cur, c_prev, d;
   logic [24:0] corr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         z     <= 6'd0;
      end else begin
         state <= state_nxt;
         z     <= z_nxt;
      end
   end

   // NOTE: the parity memory has no reset; every entry is rewritten by the parity sweep before use.
   always_ff @(posedge clk) begin
      if (state == S_PARITY)
         par_mem[z] <= col_par;
   end

   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      z_nxt     = z;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_PARITY;
               z_nxt     = 6'd0;
            end
         end
         S_PARITY: begin
            if (z == 6'd63) begin
               state_nxt = S_APPLY;
               z_nxt     = 6'd0;
            end else begin
               z_nxt = z + 6'd1;
            end
         end
         S_APPLY: begin
            if (z == 6'd63)
               state_nxt = S_DONE;
            else
               z_nxt = z + 6'd1;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Column parity of the page being read: bit x collects rows y = 0..4.
   always_comb begin
      col_par = 5'd0;
      for (int x = 0; x < 5; x++)
         col_par[x] = read_page_data[x] ^ read_page_data[5 + x] ^ read_page_data[10 + x]
                    ^ read_page_data[15 + x] ^ read_page_data[20 + x];
   end

   // Page 0 picks up C[.][63] because z - 1 wraps in 6 bits.
   always_comb begin
      c_cur  = par_mem[z];
      c_prev = par_mem[z - 6'd1];
      d      = 5'd0;
      for (int x = 0; x < 5; x++)
         d[x] = c_cur[(x + 4) % 5] ^ c_prev[(x + 1) % 5];
      corr = {d, d, d, d, d};
   end

   always_comb begin
      busy                  = (state != S_IDLE);
      done                  = (state == S_DONE);
      read_page_line_index  = z;
      write_page            = 1'b0;
      write_page_line_index = 6'd0;
      write_page_data       = 25'd0;
      if (state == S_APPLY) begin
         write_page            = 1'b1;
         write_page_line_index = z;
         write_page_data       = read_page_data ^ corr;
      end
   end

endmodule

// File: tb/tb_theta_page_unit.sv
// Self-checking bench for theta_page_unit: directed vector table, random states
// against an array-based theta model, ignored-start and mid-run reset sequences.
module tb_theta_page_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic [5:0]  read_page_line_index;
   logic [24:0] read_page_data;
   logic        write_page;
   logic [5:0]  write_page_line_index;
   logic [24:0] write_page_data;

   int checks = 0;
   int errors = 0;

   // Behavioural state register with a combinational read port.
   logic [24:0] mem      [64];
   logic [24:0] load_img [64];
   logic        load_req;
   logic [24:0] orig     [64];
   logic [24:0] expv     [64];
   int          proto_err;

   always #5 clk = ~clk;

   theta_page_unit dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .busy                  (busy),
      .done                  (done),
      .read_page_line_index  (read_page_line_index),
      .read_page_data        (read_page_data),
      .write_page            (write_page),
      .write_page_line_index (write_page_line_index),
      .write_page_data       (write_page_data)
   );

   assign read_page_data = mem[read_page_line_index];

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 64; i++) mem[i] <= load_img[i];
      end else if (write_page) begin
         mem[write_page_line_index] <= write_page_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_image();
      for (int i = 0; i < 64; i++) orig[i] = load_img[i];
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   // Theta computed from the 3-D lane view A[x][y][z].
   task automatic compute_expected();
      bit a [5][5][64];
      bit c [5][64];
      bit dd;
      for (int z = 0; z < 64; z++)
         for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
               a[x][y][z] = orig[z][5*y + x];
      for (int x = 0; x < 5; x++)
         for (int z = 0; z < 64; z++)
            c[x][z] = a[x][0][z] ^ a[x][1][z] ^ a[x][2][z] ^ a[x][3][z] ^ a[x][4][z];
      for (int z = 0; z < 64; z++) begin
         expv[z] = 25'd0;
         for (int x = 0; x < 5; x++) begin
            dd = c[(x + 4) % 5][z] ^ c[(x + 1) % 5][(z + 63) % 64];
            for (int y = 0; y < 5; y++)
               expv[z][5*y + x] = a[x][y][z] ^ dd;
         end
      end
   endtask

   // Starts a run in the current cycle; extra start pulses at the given cycle numbers.
   task automatic run_theta(input int ign_a, input int ign_b, input int ign_c,
                            output int done_cyc, output int busy_cnt,
                            output int wr_cnt, output int done_cnt);
      int cyc;
      bit seen;
      done_cyc = -1; busy_cnt = 0; wr_cnt = 0; done_cnt = 0; proto_err = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc < 400) begin
         start = (cyc == ign_a) || (cyc == ign_b) || (cyc == ign_c);
         if (busy) busy_cnt++;
         if (write_page) begin
            wr_cnt++;
            if (write_page_line_index !== read_page_line_index) proto_err++;
            if (cyc < 65 || cyc > 128) proto_err++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            seen = 1'b1;
         end
         tick();
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic check_run_timing(input string tag, input int done_cyc, input int busy_cnt,
                                   input int wr_cnt, input int done_cnt);
      check({tag, " done_cycle"}, done_cyc, 129);
      check({tag, " busy_cycles"}, busy_cnt, 129);
      check({tag, " write_cycles"}, wr_cnt, 64);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " write_protocol"}, proto_err, 0);
   endtask

   task automatic check_all_pages(input string tag);
      int bad;
      bad = 0;
      for (int z = 0; z < 64; z++) begin
         if (mem[z] !== expv[z]) begin
            bad++;
            $display("FAIL %s page %0d actual=%h required=%h", tag, z, mem[z], expv[z]);
         end
      end
      check({tag, " pages_bad"}, bad, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " write_page"}, write_page, 0);
      check({tag, " write_idx"}, write_page_line_index, 0);
      check({tag, " write_data"}, write_page_data, 0);
      check({tag, " read_idx"}, read_page_line_index, 0);
   endtask

   typedef struct {
      string       name;
      logic [24:0] fill;
      bit          has_bit;
      int          bit_page;
      logic [24:0] exp_p0;
      logic [24:0] exp_p1;
      logic [24:0] exp_p63;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int dc, bc, wc, nc;

      vecs[0] = '{"zero",   25'h0000000, 1'b0, 0,  25'h0000000, 25'h0000000, 25'h0000000};
      vecs[1] = '{"bit000", 25'h0000000, 1'b1, 0,  25'h0210843, 25'h1084210, 25'h0000000};
      vecs[2] = '{"bit063", 25'h0000000, 1'b1, 63, 25'h1084210, 25'h0000000, 25'h0210843};
      vecs[3] = '{"ones",   25'h1FFFFFF, 1'b0, 0,  25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF};

      rst = 1'b1; start = 1'b0; load_req = 1'b0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // Directed vectors.
      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 64; i++) load_img[i] = vecs[v].fill;
         if (vecs[v].has_bit) load_img[vecs[v].bit_page] = 25'h0000001;
         load_image();
         compute_expected();
         run_theta(-1, -1, -1, dc, bc, wc, nc);
         check_run_timing(vecs[v].name, dc, bc, wc, nc);
         check({vecs[v].name, " page0"}, mem[0], vecs[v].exp_p0);
         check({vecs[v].name, " page1"}, mem[1], vecs[v].exp_p1);
         check({vecs[v].name, " page63"}, mem[63], vecs[v].exp_p63);
         check_all_pages(vecs[v].name);
      end

      // Random states against the model.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 64; i++) load_img[i] = 25'($urandom);
         load_image();
         compute_expected();
         run_theta(-1, -1, -1, dc, bc, wc, nc);
         check_run_timing("random", dc, bc, wc, nc);
         check_all_pages("random");
      end

      // Ignored starts in PARITY, APPLY and DONE, then back-to-back start at cycle 130.
      for (int i = 0; i < 64; i++) load_img[i] = 25'($urandom);
      load_image();
      compute_expected();
      run_theta(10, 70, 129, dc, bc, wc, nc);
      check_run_timing("ignored_start", dc, bc, wc, nc);
      check("ignored_start idle_at_130", busy, 0);
      check_all_pages("ignored_start");
      for (int i = 0; i < 64; i++) orig[i] = mem[i];
      compute_expected();
      run_theta(-1, -1, -1, dc, bc, wc, nc);
      check("second_run done_cycle_abs", dc + 130, 259);
      check_run_timing("second_run", dc, bc, wc, nc);
      check_all_pages("second_run");

      // Reset during APPLY: rst sampled at the end of cycle 79, IDLE from cycle 80.
      for (int i = 0; i < 64; i++) load_img[i] = 25'($urandom);
      load_image();
      compute_expected();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 79; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_outputs("midrun_reset");
      for (int z = 0; z < 64; z++)
         if (z >= 15) expv[z] = orig[z];
      check_all_pages("midrun_reset");
      tick();
      check("midrun_reset stays_idle", busy, 0);
      for (int i = 0; i < 64; i++) orig[i] = mem[i];
      compute_expected();
      run_theta(-1, -1, -1, dc, bc, wc, nc);
      check_run_timing("after_reset", dc, bc, wc, nc);
      check_all_pages("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
